n1_pbus_mem_tgt: RTL and testbench
==================================

# n1_pbus_mem_tgt

Wishbone pipelined target for the N1 program bus: the responder that sits at the far end of the flow-control unit's pbus initiator and serves instruction fetches from an internal word memory. Every accepted request gets exactly one ack or err after a fixed, parameterised latency. Out-of-range fetches return err. A backdoor load port preloads program images. The block serves as the program memory in simulation and FPGA builds, and as the pbus counterpart in formal benches.

## Interface
- ADR_WIDTH, 14: pbus word-address width.
- DAT_WIDTH, 16: instruction word width.
- MEM_DEPTH, 4096: implemented words; valid addresses are 0..MEM_DEPTH-1, and MEM_DEPTH must not exceed 2^ADR_WIDTH.
- LAT, 1: request-to-response latency in cycles; legal range 1..4.
- clk_i  in  1  module clock (single clock)
- sync_rst_i  in  1  synchronous reset, active-high
- pbus_cyc_i  in  1  bus cycle indicator
- pbus_stb_i  in  1  access request
- pbus_adr_i  in  ADR_WIDTH  word address
- pbus_dat_o  out  DAT_WIDTH  read data
- pbus_ack_o  out  1  acknowledge
- pbus_err_o  out  1  error response
- pbus_stall_o  out  1  access delay
- ld_we_i  in  1  backdoor write strobe
- ld_adr_i  in  ADR_WIDTH  backdoor address
- ld_dat_i  in  DAT_WIDTH  backdoor data
- stall_inj_i  in  1  forced stall, used to exercise initiator stall handling
- prb_tgt_pend_o  out  3  number of in-flight requests (0..LAT)

## Operation
- pbus_stall_o = stall_inj_i | ld_we_i. This path is combinational and is not masked by reset.
- A request is accepted in a cycle where pbus_cyc_i & pbus_stb_i & ~pbus_stall_o is true at the rising edge.
- On accept, the block reads memory synchronously (if the address is in range) and loads pipeline stage 1 with {valid=1, err=(adr>=MEM_DEPTH), dat}.
- Response pipeline: LAT stages that shift every cycle unconditionally. The target has no backpressure, and the initiator must take every response.
- Outputs, taken from the last stage:
  - pbus_ack_o = valid & ~err & pbus_cyc_i
  - pbus_err_o = valid & err & pbus_cyc_i
  - pbus_dat_o = stage data when ack, else 0
- Abort: when pbus_cyc_i is low in a cycle, all stage valid bits clear at that edge. Pending responses are discarded and never presented later.
- Backdoor write: when ld_we_i is high, mem[ld_adr_i] <= ld_dat_i, provided ld_adr_i < MEM_DEPTH; out-of-range writes are ignored. ld_we_i stalls the bus in the same cycle, so a bus read and a load never collide.
- Data for each response is sampled at accept. A load that occurs after accept does not change that response.
- prb_tgt_pend_o = popcount of stage valid bits.
- Reset: all valid bits, pbus_ack_o, pbus_err_o, pbus_dat_o and prb_tgt_pend_o are 0. Memory contents are preserved. Reset in mid-operation discards every pending response. A request presented while sync_rst_i is high is not accepted.

## Timing
- Accept at edge T → ack or err visible during cycle T+LAT. Responses return in accept order.
- Back-to-back accepts produce back-to-back responses. Throughput is one per cycle when there is no stall.
- Stall and accept are decided in the same cycle; there is no registered stall.
- The abort takes effect at the same edge that samples pbus_cyc_i=0, so no ack or err is ever asserted while pbus_cyc_i is low.
- An accept in the same cycle as an abort is not possible, because accept requires pbus_cyc_i=1.

## Structure
- Shared package n1_pbus_pkg holds:
  - the constant PBUS_LAT_MAX = 4;
  - typedef pbus_rsp_t {valid, err, dat}.
- Sub-module n1_pbus_rsp_pipe: LAT-deep pipeline of pbus_rsp_t with flush input and pending-count output.
- The top level holds the memory array, the address-range check, the stall logic and output gating.

## Test plan
- Reset: hold sync_rst_i for 2 cycles with stb=1 → ack=err=0, dat=0, pend=0, no accept; release → first request accepted.
- LAT=1: load 0x010=0xBEEF; accept adr 0x010 at T → ack=1, dat=0xBEEF in cycle T+1 only, pend=1 then 0.
- LAT=3: 4 back-to-back accepts, adr 0..3 preloaded 0xA000..0xA003 → acks in cycles T+3..T+6 with data in order, pend peaks at 3.
- MEM_DEPTH=4096: accept adr 0x1000 → err=1, ack=0, dat=0 at T+LAT; adjacent in-range requests still return ack.
- LAT=3: accept 2 requests, drop cyc at T+1 → no ack or err in any later cycle, pend=0 from T+2.
- ld_we_i=1 (adr 0x020=0x1234) with stb=1 → stall=1, no accept that cycle; request accepted next cycle → ack with 0x1234. Separately, stall_inj_i=1 for 3 cycles → no accepts, pend unchanged.

Source files
------------

// File: rtl/n1_pbus_pkg.sv
// Shared definitions for the N1 program bus target: latency bound,
// response record carried through the response pipeline, and a small
// population-count helper for the in-flight probe.
package n1_pbus_pkg;

   // Deepest response pipeline the target supports.
   localparam int PBUS_LAT_MAX = 4;

   // Width of the data field carried in a response record.
   localparam int PBUS_DAT_W = 16;

   // One response slot: valid marks an in-flight response, err marks an
   // out-of-range fetch, dat holds the word sampled at accept time.
   typedef struct packed {
      logic                  valid;
      logic                  err;
      logic [PBUS_DAT_W-1:0] dat;
   } pbus_rsp_t;

   // Count the set bits of a stage-valid vector.
   function automatic logic [2:0] pend_count(input logic [PBUS_LAT_MAX-1:0] v);
      logic [2:0] n;
      n = 3'd0;
      for (int i = 0; i < PBUS_LAT_MAX; i++) begin
         n = n + {2'b00, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/n1_pbus_if.sv
// Wishbone pipelined program bus between the N1 fetch initiator and a
// program-memory target. Only the read path is carried: the program bus
// never writes.
interface n1_pbus_if #(
   parameter int ADR_WIDTH = 14,
   parameter int DAT_WIDTH = 16
) ();

   logic                 cyc;
   logic                 stb;
   logic [ADR_WIDTH-1:0] adr;
   logic [DAT_WIDTH-1:0] dat;
   logic                 ack;
   logic                 err;
   logic                 stall;

   modport master (
      output cyc, stb, adr,
      input  dat, ack, err, stall
   );

   modport slave (
      input  cyc, stb, adr,
      output dat, ack, err, stall
   );

endinterface

// File: rtl/n1_pbus_rsp_pipe.sv
// Fixed-latency response pipeline for the program bus target. The stages
// shift every cycle without backpressure; flush empties every stage at the
// next edge. LAT must lie in 1..PBUS_LAT_MAX.
module n1_pbus_rsp_pipe
   import n1_pbus_pkg::*;
#(
   parameter int LAT = 1
) (
   input  logic      clk_i,
   input  logic      flush,
   input  pbus_rsp_t in_rsp,
   output pbus_rsp_t out_rsp,
   output logic [2:0] pend
);

   pbus_rsp_t stage [LAT];
   logic [PBUS_LAT_MAX-1:0] valid_vec;

   // Shift the response stages each cycle, or empty them all on flush.
   always_ff @(posedge clk_i) begin
      if (flush) begin
         for (int i = 0; i < LAT; i++) begin
            stage[i] <= '0;
         end
      end else begin
         stage[0] <= in_rsp;
         for (int i = 1; i < LAT; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   // Gather stage valid bits so the in-flight count can be formed.
   always_comb begin
      valid_vec = '0;
      for (int i = 0; i < LAT; i++) begin
         valid_vec[i] = stage[i].valid;
      end
   end

   // The oldest response leaves from the last stage.
   always_comb begin
      out_rsp = stage[LAT-1];
      pend    = pend_count(valid_vec);
   end

endmodule

// File: rtl/n1_pbus_mem_tgt.sv
// Program-memory target for the N1 program bus. Every accepted fetch gets
// exactly one ack or err LAT cycles later; fetches beyond MEM_DEPTH get err.
// A backdoor load port writes the array and stalls the bus while it does so,
// so a fetch and a load never touch the memory in the same cycle.
module n1_pbus_mem_tgt
   import n1_pbus_pkg::*;
#(
   parameter int ADR_WIDTH = 14,
   parameter int DAT_WIDTH = 16,
   parameter int MEM_DEPTH = 4096,
   parameter int LAT       = 1
) (
   input  logic                 clk_i,
   input  logic                 sync_rst_i,
   n1_pbus_if.slave             pbus,
   input  logic                 ld_we_i,
   input  logic [ADR_WIDTH-1:0] ld_adr_i,
   input  logic [DAT_WIDTH-1:0] ld_dat_i,
   input  logic                 stall_inj_i,
   output logic [2:0]           prb_tgt_pend_o
);

   localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [ADR_WIDTH:0] DEPTH_A = (ADR_WIDTH+1)'(MEM_DEPTH);

   logic [DAT_WIDTH-1:0] mem [MEM_DEPTH];

   logic             stall;
   logic             accept;
   logic             flush;
   logic             rd_in_range;
   logic             ld_in_range;
   logic [IDX_W-1:0] rd_idx;
   logic [IDX_W-1:0] ld_idx;
   pbus_rsp_t        rd_rsp;
   pbus_rsp_t        last_rsp;
   logic             ack;
   logic             err;
   logic [DAT_WIDTH-1:0] dat;

   // Stall is purely combinational and deliberately ignores reset, so the
   // initiator sees a load or an injected stall in the very same cycle.
   always_comb begin
      stall       = stall_inj_i | ld_we_i;
      accept      = pbus.cyc & pbus.stb & ~stall & ~sync_rst_i;
      flush       = sync_rst_i | ~pbus.cyc;
      rd_in_range = ({1'b0, pbus.adr} < DEPTH_A);
      ld_in_range = ({1'b0, ld_adr_i} < DEPTH_A);
      rd_idx      = pbus.adr[IDX_W-1:0];
      ld_idx      = ld_adr_i[IDX_W-1:0];
   end

   // Backdoor image load; the array has no reset so a program survives it.
   always_ff @(posedge clk_i) begin
      if (ld_we_i && ld_in_range) begin
         mem[ld_idx] <= ld_dat_i;
      end
   end

   // Build the response record for this cycle's fetch; the data is captured
   // into the first pipeline stage at the accept edge, so later loads to the
   // same address cannot alter a response already in flight.
   always_comb begin
      rd_rsp = '0;
      if (accept) begin
         rd_rsp.valid = 1'b1;
         rd_rsp.err   = ~rd_in_range;
         if (rd_in_range) begin
            rd_rsp.dat = PBUS_DAT_W'(mem[rd_idx]);
         end else begin
            rd_rsp.dat = '0;
         end
      end else begin
         rd_rsp = '0;
      end
   end

   n1_pbus_rsp_pipe #(
      .LAT (LAT)
   ) u_rsp_pipe (
      .clk_i   (clk_i),
      .flush   (flush),
      .in_rsp  (rd_rsp),
      .out_rsp (last_rsp),
      .pend    (prb_tgt_pend_o)
   );

   // Gate responses with cyc so nothing is ever presented to an initiator
   // that has abandoned its cycle; data reads as zero unless acked.
   always_comb begin
      ack = last_rsp.valid & ~last_rsp.err & pbus.cyc;
      err = last_rsp.valid &  last_rsp.err & pbus.cyc;
      if (ack) begin
         dat = last_rsp.dat[DAT_WIDTH-1:0];
      end else begin
         dat = '0;
      end
   end

   assign pbus.stall = stall;
   assign pbus.ack   = ack;
   assign pbus.err   = err;
   assign pbus.dat   = dat;

endmodule

// File: tb/tb_n1_pbus_mem_tgt.sv
// Directed bench for n1_pbus_mem_tgt. Two targets, LAT=1 and LAT=3, see the
// same stimulus each cycle; every cycle lists the hand-computed outputs both
// must present while that cycle's inputs are applied.
module tb_n1_pbus_mem_tgt;

   localparam logic H = 1'b1;
   localparam logic L = 1'b0;
   localparam logic [15:0] Z = 16'h0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        cyc;
   logic        stb;
   logic [13:0] adr;
   logic        ld_we;
   logic [13:0] ld_adr;
   logic [15:0] ld_dat;
   logic        inj;
   logic [2:0]  pend1;
   logic [2:0]  pend3;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   n1_pbus_if #(.ADR_WIDTH(14), .DAT_WIDTH(16)) bus1 ();
   n1_pbus_if #(.ADR_WIDTH(14), .DAT_WIDTH(16)) bus3 ();

   assign bus1.cyc = cyc;
   assign bus1.stb = stb;
   assign bus1.adr = adr;
   assign bus3.cyc = cyc;
   assign bus3.stb = stb;
   assign bus3.adr = adr;

   n1_pbus_mem_tgt #(.ADR_WIDTH(14), .DAT_WIDTH(16), .MEM_DEPTH(4096), .LAT(1)) u_dut1 (
      .clk_i          (clk),
      .sync_rst_i     (rst),
      .pbus           (bus1.slave),
      .ld_we_i        (ld_we),
      .ld_adr_i       (ld_adr),
      .ld_dat_i       (ld_dat),
      .stall_inj_i    (inj),
      .prb_tgt_pend_o (pend1)
   );

   n1_pbus_mem_tgt #(.ADR_WIDTH(14), .DAT_WIDTH(16), .MEM_DEPTH(4096), .LAT(3)) u_dut3 (
      .clk_i          (clk),
      .sync_rst_i     (rst),
      .pbus           (bus3.slave),
      .ld_we_i        (ld_we),
      .ld_adr_i       (ld_adr),
      .ld_dat_i       (ld_dat),
      .stall_inj_i    (inj),
      .prb_tgt_pend_o (pend3)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Apply one cycle of inputs, check both targets mid-cycle, then advance.
   task automatic run(input string tag,
                      input logic r, input logic c, input logic s, input logic [13:0] a,
                      input logic lw, input logic [13:0] la, input logic [15:0] ld,
                      input logic ij, input logic st,
                      input logic a1, input logic e1, input logic [15:0] d1, input logic [2:0] p1,
                      input logic a3, input logic e3, input logic [15:0] d3, input logic [2:0] p3);
      rst = r; cyc = c; stb = s; adr = a;
      ld_we = lw; ld_adr = la; ld_dat = ld; inj = ij;
      @(negedge clk);
      check({tag, ".stall1"}, 32'(bus1.stall), 32'(st));
      check({tag, ".ack1"},   32'(bus1.ack),   32'(a1));
      check({tag, ".err1"},   32'(bus1.err),   32'(e1));
      check({tag, ".dat1"},   32'(bus1.dat),   32'(d1));
      check({tag, ".pend1"},  32'(pend1),      32'(p1));
      check({tag, ".stall3"}, 32'(bus3.stall), 32'(st));
      check({tag, ".ack3"},   32'(bus3.ack),   32'(a3));
      check({tag, ".err3"},   32'(bus3.err),   32'(e3));
      check({tag, ".dat3"},   32'(bus3.dat),   32'(d3));
      check({tag, ".pend3"},  32'(pend3),      32'(p3));
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = H; cyc = L; stb = L; adr = 14'h000;
      ld_we = L; ld_adr = 14'h000; ld_dat = Z; inj = L;
      @(posedge clk);
      #1;

      // Image load under reset: memory must survive it; load stalls the bus.
      run("L1", H,L,L,14'h000, H,14'h010,16'hBEEF, L,H, L,L,Z,3'd0, L,L,Z,3'd0);
      run("L2", H,L,L,14'h000, H,14'h000,16'hA000, L,H, L,L,Z,3'd0, L,L,Z,3'd0);
      run("L3", H,L,L,14'h000, H,14'h001,16'hA001, L,H, L,L,Z,3'd0, L,L,Z,3'd0);
      run("L4", H,L,L,14'h000, H,14'h002,16'hA002, L,H, L,L,Z,3'd0, L,L,Z,3'd0);
      run("L5", H,L,L,14'h000, H,14'h003,16'hA003, L,H, L,L,Z,3'd0, L,L,Z,3'd0);
      run("L6", H,L,L,14'h000, H,14'h0FFF,16'h5A5A, L,H, L,L,Z,3'd0, L,L,Z,3'd0);
      run("L7", H,L,L,14'h000, H,14'h1000,16'hDEAD, L,H, L,L,Z,3'd0, L,L,Z,3'd0);
      run("L8", H,L,L,14'h000, H,14'h011,16'h0011, L,H, L,L,Z,3'd0, L,L,Z,3'd0);

      // Request held during reset is never accepted.
      run("R1", H,H,H,14'h010, L,14'h000,Z, L,L, L,L,Z,3'd0, L,L,Z,3'd0);
      run("R2", H,H,H,14'h010, L,14'h000,Z, L,L, L,L,Z,3'd0, L,L,Z,3'd0);

      // Single fetch of 0x010 after release.
      run("A1", L,H,H,14'h010, L,14'h000,Z, L,L, L,L,Z,3'd0, L,L,Z,3'd0);
      run("A2", L,H,L,14'h010, L,14'h000,Z, L,L, H,L,16'hBEEF,3'd1, L,L,Z,3'd1);
      run("A3", L,H,L,14'h010, L,14'h000,Z, L,L, L,L,Z,3'd0, L,L,Z,3'd1);
      run("A4", L,H,L,14'h010, L,14'h000,Z, L,L, L,L,Z,3'd0, H,L,16'hBEEF,3'd1);
      run("A5", L,H,L,14'h010, L,14'h000,Z, L,L, L,L,Z,3'd0, L,L,Z,3'd0);

      // Four back-to-back fetches, responses in order.
      run("B1", L,H,H,14'h000, L,14'h000,Z, L,L, L,L,Z,3'd0, L,L,Z,3'd0);
      run("B2", L,H,H,14'h001, L,14'h000,Z, L,L, H,L,16'hA000,3'd1, L,L,Z,3'd1);
      run("B3", L,H,H,14'h002, L,14'h000,Z, L,L, H,L,16'hA001,3'd1, L,L,Z,3'd2);
      run("B4", L,H,H,14'h003, L,14'h000,Z, L,L, H,L,16'hA002,3'd1, H,L,16'hA000,3'd3);
      run("B5", L,H,L,14'h000, L,14'h000,Z, L,L, H,L,16'hA003,3'd1, H,L,16'hA001,3'd3);
      run("B6", L,H,L,14'h000, L,14'h000,Z, L,L, L,L,Z,3'd0, H,L,16'hA002,3'd2);
      run("B7", L,H,L,14'h000, L,14'h000,Z, L,L, L,L,Z,3'd0, H,L,16'hA003,3'd1);
      run("B8", L,H,L,14'h000, L,14'h000,Z, L,L, L,L,Z,3'd0, L,L,Z,3'd0);

      // Last word, first out-of-range word, then an in-range word.
      run("E1", L,H,H,14'h0FFF, L,14'h000,Z, L,L, L,L,Z,3'd0, L,L,Z,3'd0);
      run("E2", L,H,H,14'h1000, L,14'h000,Z, L,L, H,L,16'h5A5A,3'd1, L,L,Z,3'd1);
      run("E3", L,H,H,14'h011, L,14'h000,Z, L,L, L,H,Z,3'd1, L,L,Z,3'd2);
      run("E4", L,H,L,14'h000, L,14'h000,Z, L,L, H,L,16'h0011,3'd1, H,L,16'h5A5A,3'd3);
      run("E5", L,H,L,14'h000, L,14'h000,Z, L,L, L,L,Z,3'd0, L,H,Z,3'd2);
      run("E6", L,H,L,14'h000, L,14'h000,Z, L,L, L,L,Z,3'd0, H,L,16'h0011,3'd1);
      run("E7", L,H,L,14'h000, L,14'h000,Z, L,L, L,L,Z,3'd0, L,L,Z,3'd0);

      // Two accepts, then cyc dropped: pending responses are discarded.
      run("C1", L,H,H,14'h000, L,14'h000,Z, L,L, L,L,Z,3'd0, L,L,Z,3'd0);
      run("C2", L,H,H,14'h001, L,14'h000,Z, L,L, H,L,16'hA000,3'd1, L,L,Z,3'd1);
      run("C3", L,L,L,14'h000, L,14'h000,Z, L,L, L,L,Z,3'd1, L,L,Z,3'd2);
      run("C4", L,H,L,14'h000, L,14'h000,Z, L,L, L,L,Z,3'd0, L,L,Z,3'd0);
      run("C5", L,H,L,14'h000, L,14'h000,Z, L,L, L,L,Z,3'd0, L,L,Z,3'd0);
      run("C6", L,H,L,14'h000, L,14'h000,Z, L,L, L,L,Z,3'd0, L,L,Z,3'd0);

      // Load collides with a request: stalled, then accepted with new data.
      run("D1", L,H,H,14'h020, H,14'h020,16'h1234, L,H, L,L,Z,3'd0, L,L,Z,3'd0);
      run("D2", L,H,H,14'h020, L,14'h000,Z, L,L, L,L,Z,3'd0, L,L,Z,3'd0);
      run("D3", L,H,L,14'h000, L,14'h000,Z, L,L, H,L,16'h1234,3'd1, L,L,Z,3'd1);
      run("D4", L,H,L,14'h000, L,14'h000,Z, L,L, L,L,Z,3'd0, L,L,Z,3'd1);
      run("D5", L,H,L,14'h000, L,14'h000,Z, L,L, L,L,Z,3'd0, H,L,16'h1234,3'd1);
      run("D6", L,H,L,14'h000, L,14'h000,Z, L,L, L,L,Z,3'd0, L,L,Z,3'd0);

      // Load after accept leaves the in-flight response untouched.
      run("F1", L,H,H,14'h020, L,14'h000,Z, L,L, L,L,Z,3'd0, L,L,Z,3'd0);
      run("F2", L,H,H,14'h020, H,14'h020,16'h9999, L,H, H,L,16'h1234,3'd1, L,L,Z,3'd1);
      run("F3", L,H,L,14'h000, L,14'h000,Z, L,L, L,L,Z,3'd0, L,L,Z,3'd1);
      run("F4", L,H,L,14'h000, L,14'h000,Z, L,L, L,L,Z,3'd0, H,L,16'h1234,3'd1);
      run("F5", L,H,H,14'h020, L,14'h000,Z, L,L, L,L,Z,3'd0, L,L,Z,3'd0);
      run("F6", L,H,L,14'h000, L,14'h000,Z, L,L, H,L,16'h9999,3'd1, L,L,Z,3'd1);
      run("F7", L,H,L,14'h000, L,14'h000,Z, L,L, L,L,Z,3'd0, L,L,Z,3'd1);
      run("F8", L,H,L,14'h000, L,14'h000,Z, L,L, L,L,Z,3'd0, H,L,16'h9999,3'd1);
      run("F9", L,H,L,14'h000, L,14'h000,Z, L,L, L,L,Z,3'd0, L,L,Z,3'd0);

      // Injected stall for three cycles blocks new accepts only.
      run("G1", L,H,H,14'h003, L,14'h000,Z, L,L, L,L,Z,3'd0, L,L,Z,3'd0);
      run("G2", L,H,H,14'h002, L,14'h000,Z, H,H, H,L,16'hA003,3'd1, L,L,Z,3'd1);
      run("G3", L,H,H,14'h002, L,14'h000,Z, H,H, L,L,Z,3'd0, L,L,Z,3'd1);
      run("G4", L,H,H,14'h002, L,14'h000,Z, H,H, L,L,Z,3'd0, H,L,16'hA003,3'd1);
      run("G5", L,H,L,14'h000, L,14'h000,Z, L,L, L,L,Z,3'd0, L,L,Z,3'd0);

      // Reset in mid-flight discards the pending response.
      run("H1", L,H,H,14'h001, L,14'h000,Z, L,L, L,L,Z,3'd0, L,L,Z,3'd0);
      run("H2", H,H,L,14'h000, L,14'h000,Z, L,L, H,L,16'hA001,3'd1, L,L,Z,3'd1);
      run("H3", L,H,L,14'h000, L,14'h000,Z, L,L, L,L,Z,3'd0, L,L,Z,3'd0);
      run("H4", L,H,L,14'h000, L,14'h000,Z, L,L, L,L,Z,3'd0, L,L,Z,3'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
